// File: rtl/v_wb_arb.sv
// v_wb_arb: vector writeback merge stage.
// Merges NUM_CH vector-result channels into the single VRF write port. Each
// channel has a small FIFO with a valid/ready handshake. A round-robin arbiter
// drains one entry per cycle into a registered VRF write port.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   vwb_valid_i       per-channel write request valid            [NUM_CH]
//   vwb_ready_o       per-channel FIFO not full                  [NUM_CH]
//   vwb_addr_i        flattened dest vreg addresses, ch i at [i*VREG_AW +: VREG_AW]
//   vwb_data_i        flattened write data, ch i at [i*VREG_DW +: VREG_DW]
//   vwb_en_o          VRF write enable (registered)
//   vwb_addr_o        VRF write address (registered)
//   vwb_data_o        VRF write data (registered)
//   vwb_ch_o          source channel of current write (registered)
//   vwb_busy_o        any FIFO non-empty or write in progress (fence/flush)
//   vwb_stall_cnt_o   per-channel 16-bit saturating stall counters
//                     (present only when V_WB_PERF_EN is defined)
//
// Optional feature macro: V_WB_PERF_EN

module v_wb_arb #(
  parameter int unsigned NUM_CH     = 3,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned VREG_DW    = 256,
  parameter int unsigned VREG_AW    = 5,
  localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CH-1:0]           vwb_valid_i,
  output logic [NUM_CH-1:0]           vwb_ready_o,
  input  logic [NUM_CH*VREG_AW-1:0]   vwb_addr_i,
  input  logic [NUM_CH*VREG_DW-1:0]   vwb_data_i,
  output logic                        vwb_en_o,
  output logic [VREG_AW-1:0]          vwb_addr_o,
  output logic [VREG_DW-1:0]          vwb_data_o,
  output logic [CH_W-1:0]             vwb_ch_o,
  output logic                        vwb_busy_o
`ifdef V_WB_PERF_EN
  ,
  output logic [NUM_CH*16-1:0]        vwb_stall_cnt_o
`endif
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  // FIFO storage (no reset needed: validity is tracked by count)
  logic [VREG_AW-1:0] addr_mem [NUM_CH][FIFO_DEPTH];
  logic [VREG_DW-1:0] data_mem [NUM_CH][FIFO_DEPTH];

  logic [PTR_W-1:0]   wr_ptr   [NUM_CH];
  logic [PTR_W-1:0]   rd_ptr   [NUM_CH];
  logic [CNT_W-1:0]   count    [NUM_CH];

  logic [NUM_CH-1:0]  full_c;
  logic [NUM_CH-1:0]  nempty_c;
  logic [NUM_CH-1:0]  push_c;
  logic [NUM_CH-1:0]  pop_c;

  logic               grant_c;
  logic [CH_W-1:0]    gnt_ch_c;
  logic [31:0]        scan_idx_c;
  logic [CH_W-1:0]    last_grant;

  // FIFO status, derived only from registered counts
  always_comb begin
    full_c   = '0;
    nempty_c = '0;
    push_c   = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      full_c[i]   = (count[i] == CNT_W'(FIFO_DEPTH));
      nempty_c[i] = (count[i] != '0);
      push_c[i]   = vwb_valid_i[i] & ~full_c[i];
    end
  end

  assign vwb_ready_o = ~full_c;

  // Round-robin search starting one past the last granted channel
  always_comb begin
    grant_c    = 1'b0;
    gnt_ch_c   = '0;
    pop_c      = '0;
    scan_idx_c = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      scan_idx_c = 32'(last_grant) + 32'd1 + 32'(k);
      if (scan_idx_c >= 32'(NUM_CH)) begin
        scan_idx_c = scan_idx_c - 32'(NUM_CH);
      end
      if (!grant_c && nempty_c[CH_W'(scan_idx_c)]) begin
        grant_c  = 1'b1;
        gnt_ch_c = CH_W'(scan_idx_c);
      end
    end
    pop_c[gnt_ch_c] = grant_c;
  end

  // FIFO entry writes
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (push_c[i]) begin
        addr_mem[i][wr_ptr[i]] <= vwb_addr_i[i*VREG_AW +: VREG_AW];
        data_mem[i][wr_ptr[i]] <= vwb_data_i[i*VREG_DW +: VREG_DW];
      end
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally (power-of-two depth)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (push_c[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
        if (pop_c[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
        case ({push_c[i], pop_c[i]})
          2'b10:   count[i] <= count[i] + CNT_W'(1);
          2'b01:   count[i] <= count[i] - CNT_W'(1);
          default: count[i] <= count[i];
        endcase
      end
    end
  end

  // VRF write port register and arbiter history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vwb_en_o   <= 1'b0;
      vwb_addr_o <= '0;
      vwb_data_o <= '0;
      vwb_ch_o   <= '0;
      last_grant <= CH_W'(NUM_CH - 1);
    end else begin
      vwb_en_o <= grant_c;
      if (grant_c) begin
        vwb_addr_o <= addr_mem[gnt_ch_c][rd_ptr[gnt_ch_c]];
        vwb_data_o <= data_mem[gnt_ch_c][rd_ptr[gnt_ch_c]];
        vwb_ch_o   <= gnt_ch_c;
        last_grant <= gnt_ch_c;
      end
    end
  end

  assign vwb_busy_o = (|nempty_c) | vwb_en_o;

`ifdef V_WB_PERF_EN
  logic [15:0] stall_cnt [NUM_CH];

  // Saturating count of cycles a channel is refused by a full FIFO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) stall_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (vwb_valid_i[i] && full_c[i] && (stall_cnt[i] != 16'hFFFF)) begin
          stall_cnt[i] <= stall_cnt[i] + 16'd1;
        end
      end
    end
  end

  always_comb begin
    vwb_stall_cnt_o = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      vwb_stall_cnt_o[i*16 +: 16] = stall_cnt[i];
    end
  end
`endif

endmodule

// File: tb/tb_v_wb_arb.sv
// tb_v_wb_arb: self-checking bench for v_wb_arb (default parameters).
// Directed vector table for the basic arbitration order, then hand-written
// sequences for single write latency, sustained contention with full FIFOs,
// pointer wrap, and asynchronous reset mid-burst.

module tb_v_wb_arb;

  localparam int unsigned NCH = 3;
  localparam int unsigned AW  = 5;
  localparam int unsigned DW  = 256;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH-1:0]    valid;
  logic [NCH-1:0]    ready;
  logic [NCH*AW-1:0] addr_in;
  logic [NCH*DW-1:0] data_in;
  logic              en;
  logic [AW-1:0]     addr_out;
  logic [DW-1:0]     data_out;
  logic [1:0]        ch_out;
  logic              busy;
`ifdef V_WB_PERF_EN
  logic [NCH*16-1:0] stall_cnt;
`endif

  v_wb_arb dut (
    .clk         (clk),
    .rst         (rst),
    .vwb_valid_i (valid),
    .vwb_ready_o (ready),
    .vwb_addr_i  (addr_in),
    .vwb_data_i  (data_in),
    .vwb_en_o    (en),
    .vwb_addr_o  (addr_out),
    .vwb_data_o  (data_out),
    .vwb_ch_o    (ch_out),
    .vwb_busy_o  (busy)
`ifdef V_WB_PERF_EN
    ,
    .vwb_stall_cnt_o (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] mk(input logic [4:0] a);
    return {8{{27'h15A5A5A, a}}};
  endfunction

  typedef struct {
    logic [2:0] v;
    logic [4:0] a0, a1, a2;
    logic       en;
    logic [4:0] addr;
    logic [1:0] ch;
    logic [2:0] rdy;
    logic       busy;
  } vec_t;

  vec_t tbl [10];

  // Reference model state
  typedef struct {
    int          ch;
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t         mq [$];
  int           m_cnt [NCH];
  int           m_seq [NCH];
  int           m_stall [NCH];
  int           m_last;
  logic         m_en;
  logic [4:0]   m_addr;
  logic [255:0] m_data;
  int           m_ch;
  logic         saw_full_pop;

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < NCH; i++) begin
      m_cnt[i] = 0;
      m_stall[i] = 0;
    end
    m_last = NCH - 1;
    m_en   = 1'b0;
    m_addr = '0;
    m_data = '0;
    m_ch   = 0;
  endtask

  // One cycle: drive v, predict the grant/push, check after the edge
  task automatic step(input logic [2:0] v);
    logic [2:0]  rm;
    int          g;
    int          idx;
    logic [4:0]  a;
    logic [31:0] d;
    int          tot;
    for (int i = 0; i < NCH; i++) rm[i] = (m_cnt[i] < 4);
    chk("ready", 256'(ready), 256'(rm));
    g = -1;
    for (int k = 0; k < NCH; k++) begin
      idx = (m_last + 1 + k) % NCH;
      if (g < 0 && m_cnt[idx] > 0) g = idx;
    end
    m_en = 1'b0;
    if (g >= 0) begin
      for (int j = 0; j < mq.size(); j++) begin
        if (mq[j].ch == g) begin
          m_addr = mq[j].a;
          m_data = {8{mq[j].d}};
          mq.delete(j);
          break;
        end
      end
      if (!rm[2] && g == 2) saw_full_pop = 1'b1;
      m_en = 1'b1;
      m_ch = g;
      m_cnt[g]--;
      m_last = g;
    end
    valid = v;
    for (int i = 0; i < NCH; i++) begin
      a = 5'(i * 8 + m_seq[i] % 8);
      d = {8'(i), 24'(m_seq[i])};
      addr_in[i*AW +: AW] = a;
      data_in[i*DW +: DW] = {8{d}};
      if (v[i] && rm[i]) begin
        mq.push_back('{i, a, d});
        m_cnt[i]++;
        m_seq[i]++;
      end
      if (v[i] && !rm[i] && m_stall[i] < 65535) m_stall[i]++;
    end
    @(posedge clk);
    #1;
    tot = 0;
    for (int i = 0; i < NCH; i++) tot += m_cnt[i];
    chk("en",   256'(en),       256'(m_en));
    chk("addr", 256'(addr_out), 256'(m_addr));
    chk("data", data_out,       m_data);
    chk("ch",   256'(ch_out),   256'(m_ch));
    chk("busy", 256'(busy),     256'((tot > 0) || m_en));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{3'b000, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 2'd0, 3'b111, 1'b0};
    tbl[1] = '{3'b111, 5'd1, 5'd2, 5'd3, 1'b0, 5'd0, 2'd0, 3'b111, 1'b1};
    tbl[2] = '{3'b000, 5'd0, 5'd0, 5'd0, 1'b1, 5'd1, 2'd0, 3'b111, 1'b1};
    tbl[3] = '{3'b000, 5'd0, 5'd0, 5'd0, 1'b1, 5'd2, 2'd1, 3'b111, 1'b1};
    tbl[4] = '{3'b000, 5'd0, 5'd0, 5'd0, 1'b1, 5'd3, 2'd2, 3'b111, 1'b1};
    tbl[5] = '{3'b111, 5'd4, 5'd5, 5'd6, 1'b0, 5'd3, 2'd2, 3'b111, 1'b1};
    tbl[6] = '{3'b000, 5'd0, 5'd0, 5'd0, 1'b1, 5'd4, 2'd0, 3'b111, 1'b1};
    tbl[7] = '{3'b000, 5'd0, 5'd0, 5'd0, 1'b1, 5'd5, 2'd1, 3'b111, 1'b1};
    tbl[8] = '{3'b000, 5'd0, 5'd0, 5'd0, 1'b1, 5'd6, 2'd2, 3'b111, 1'b1};
    tbl[9] = '{3'b000, 5'd0, 5'd0, 5'd0, 1'b0, 5'd6, 2'd2, 3'b111, 1'b0};

    saw_full_pop = 1'b0;
    for (int i = 0; i < NCH; i++) m_seq[i] = 0;
    rst     = 1'b1;
    valid   = '0;
    addr_in = '0;
    data_in = '0;

    // Reset state
    #1;
    chk("rst_en",    256'(en),       256'(0));
    chk("rst_addr",  256'(addr_out), 256'(0));
    chk("rst_data",  data_out,       256'(0));
    chk("rst_ch",    256'(ch_out),   256'(0));
    chk("rst_busy",  256'(busy),     256'(0));
    chk("rst_ready", 256'(ready),    256'(3'b111));
    #11;
    rst = 1'b0;

    // Directed vector table: round-robin order from reset and on a second burst
    for (int t = 0; t < 10; t++) begin
      valid   = tbl[t].v;
      addr_in = {tbl[t].a2, tbl[t].a1, tbl[t].a0};
      data_in = {mk(tbl[t].a2), mk(tbl[t].a1), mk(tbl[t].a0)};
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_en", t),    256'(en),       256'(tbl[t].en));
      chk($sformatf("tbl%0d_addr", t),  256'(addr_out), 256'(tbl[t].addr));
      chk($sformatf("tbl%0d_data", t),  data_out,
          (tbl[t].addr == 5'd0) ? 256'(0) : mk(tbl[t].addr));
      chk($sformatf("tbl%0d_ch", t),    256'(ch_out),   256'(tbl[t].ch));
      chk($sformatf("tbl%0d_ready", t), 256'(ready),    256'(tbl[t].rdy));
      chk($sformatf("tbl%0d_busy", t),  256'(busy),     256'(tbl[t].busy));
    end

    // Single push on ch1: one-cycle write two edges later, then idle
    valid   = 3'b010;
    addr_in = '0;
    data_in = '0;
    addr_in[AW +: AW] = 5'd5;
    data_in[DW +: DW] = {32{8'hA5}};
    @(posedge clk);
    #1;
    valid = '0;
    chk("single_en_k", 256'(en), 256'(0));
    @(posedge clk);
    #1;
    chk("single_en",   256'(en),       256'(1));
    chk("single_addr", 256'(addr_out), 256'(5));
    chk("single_data", data_out,       {32{8'hA5}});
    chk("single_ch",   256'(ch_out),   256'(1));
    chk("single_busy", 256'(busy),     256'(1));
    @(posedge clk);
    #1;
    chk("single_en_off",   256'(en),       256'(0));
    chk("single_busy_off", 256'(busy),     256'(0));
    chk("single_hold",     256'(addr_out), 256'(5));

    // Clean restart for the model-driven sequences
    rst = 1'b1;
    #2;
    rst = 1'b0;
    model_reset();

    // Sustained contention: FIFOs fill, pop-while-full keeps ready low, wrap
    for (int c = 0; c < 20; c++) step(3'b111);
    for (int c = 0; c < 20; c++) begin
      if (mq.size() == 0 && !m_en) break;
      step(3'b000);
    end
    step(3'b000);
    chk("full_pop_ready_low", 256'(saw_full_pop), 256'(1));
`ifdef V_WB_PERF_EN
    for (int i = 0; i < NCH; i++) begin
      chk($sformatf("stall%0d", i), 256'(stall_cnt[i*16 +: 16]), 256'(m_stall[i]));
    end
`endif

    // Asynchronous reset mid-burst with entries pending
    step(3'b111);
    step(3'b111);
    chk("pre_rst_en", 256'(en), 256'(1));
    #3;
    rst = 1'b1;
    #1;
    chk("arst_en",    256'(en),       256'(0));
    chk("arst_addr",  256'(addr_out), 256'(0));
    chk("arst_data",  data_out,       256'(0));
    chk("arst_ch",    256'(ch_out),   256'(0));
    chk("arst_busy",  256'(busy),     256'(0));
    chk("arst_ready", 256'(ready),    256'(3'b111));
    valid = '0;
    @(posedge clk);
    #1;
    chk("arst_hold_en", 256'(en), 256'(0));
    rst = 1'b0;
    model_reset();
    step(3'b000);
    step(3'b000);
    step(3'b101);
    step(3'b000);
    chk("post_rst_first_ch", 256'(ch_out), 256'(0));
    step(3'b000);
    step(3'b000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
